// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file address width and dumper state encoding
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} state_t;
endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper: on start, reads registers 0..NUM_REGS-1 via rf_read_reg/rf_data and streams them as out_valid/out_ready beats (out_data/out_index/out_last); abort cancels, busy/done report status
module regfile_dumper import rf_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0]     rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  state_t state, nxt;
  logic [REG_ADDR_W-1:0] idx;
  logic last;
  assign last = idx == REG_ADDR_W'(NUM_REGS - 1);
  always_comb begin
    nxt = state == IDLE ? (start ? READ : IDLE) :
          state == READ ? (abort ? IDLE : SEND) :
          state == SEND ? (abort ? IDLE : !out_ready ? SEND : last ? FINISH : READ) :
          IDLE;
    rf_read_reg = state == READ ? idx : '0;
    out_valid   = state == SEND;
    busy        = state != IDLE;
    done        = state == FINISH;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) idx <= '0;
      else if (state == SEND && out_ready && !abort && !last) idx <= idx + 1'b1;
      if (state == READ) begin
        out_data  <= rf_data;
        out_index <= idx;
        out_last  <= last;
      end
    end
endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: directed and randomized checks of regfile_dumper against a beat-sequence reference model
module tb_regfile_dumper;
  localparam int N = 32;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, out_ready = 0, s4 = 0;
  logic [4:0] rf_read_reg, out_index, rf4_reg, o4_index;
  logic [31:0] rf_data, out_data, rf4, o4_data;
  logic out_valid, out_last, busy, done, o4_valid, o4_last, b4, d4;
  logic [31:0] regs [32];
  int checks = 0, errors = 0;

  assign rf_data = regs[rf_read_reg];
  assign rf4     = regs[rf4_reg];

  always #5 clk = ~clk;

  regfile_dumper #(.NUM_REGS(N), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rf_read_reg(rf_read_reg), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done));

  regfile_dumper #(.NUM_REGS(4), .DATA_W(32)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(s4), .abort(1'b0),
    .rf_read_reg(rf4_reg), .rf_data(rf4), .out_valid(o4_valid),
    .out_ready(1'b1), .out_data(o4_data), .out_index(o4_index),
    .out_last(o4_last), .busy(b4), .done(d4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready always high, 1 ready toggles every 3 cycles, 2 random ready.
  // abort_at / busy_start_at / rst_at: beat index at which to inject that event (-1 = never).
  task automatic dump(input int mode, input int abort_at, input int busy_start_at, input int rst_at);
    int exp_idx = 0;
    int dones = 0;
    bit fin = 0;
    start = 1;
    @(negedge clk);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      start = 0;
      abort = 0;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(((cyc / 3) % 2) == 1) : 1'($urandom_range(0, 1));
      if (done) begin
        dones++;
        fin = 1;
        chk("beats_before_done", exp_idx, N);
      end else if (out_valid) begin
        chk("index", out_index, exp_idx);
        chk("data", out_data, regs[exp_idx]);
        chk("last", out_last, exp_idx == N - 1);
        if (mode == 0) chk("beat_timing", cyc, 2 * exp_idx + 1);
        if (exp_idx == rst_at) begin
          #2 reset_n = 0;
          #1;
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_data", out_data, 0);
          chk("rst_index", out_index, 0);
          chk("rst_last", out_last, 0);
          out_ready = 0;
          @(negedge clk);
          reset_n = 1;
          repeat (3) begin
            @(negedge clk);
            chk("rst_needs_start", busy, 0);
            chk("rst_no_done", done, 0);
          end
          return;
        end
        if (exp_idx == busy_start_at) start = 1;
        if (exp_idx == abort_at) begin
          abort = 1;
          @(negedge clk);
          abort = 0;
          out_ready = 0;
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
          end
          return;
        end
        if (out_ready) exp_idx++;
      end else if (busy) chk("rf_addr", rf_read_reg, exp_idx);
      @(negedge clk);
    end
    out_ready = 0;
    if (!fin) chk("dump_timeout", 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("single_done", done, 0);
      chk("idle_after_done", busy, 0);
    end
    chk("done_count", dones, 1);
    chk("idle_addr", rf_read_reg, 0);
  endtask

  initial begin
    int k, d4s;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    repeat (2) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data", out_data, 0);
    chk("reset_index", out_index, 0);
    chk("reset_last", out_last, 0);
    chk("reset_addr", rf_read_reg, 0);
    reset_n = 1;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_idle_ignored", busy, 0);
    dump(0, -1, -1, -1);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    dump(1, -1, -1, -1);
    dump(0, 10, -1, -1);
    dump(2, -1, -1, -1);
    dump(0, -1, 5, -1);
    dump(0, -1, -1, 20);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    dump(2, -1, -1, -1);
    k = 0;
    d4s = 0;
    s4 = 1;
    @(negedge clk);
    s4 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (o4_valid) begin
        chk("n4_index", o4_index, k);
        chk("n4_data", o4_data, regs[k]);
        chk("n4_last", o4_last, k == 3);
        k++;
      end
      if (d4) begin
        d4s++;
        chk("n4_done_after_last", k, 4);
      end
      @(negedge clk);
    end
    chk("n4_beats", k, 4);
    chk("n4_done_count", d4s, 1);
    chk("n4_idle", b4, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
